// File: rtl/alu_pkg.sv
// Shared encodings for the RV32 ALU issue path: ALU op codes, RV32I opcode/funct constants.
// Also holds the decoded-control struct carried in the issue stage's D register.
package alu_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [5:0] OP_ALU_NOP  = 6'b000000;
   localparam logic [5:0] OP_ALU_ADD  = 6'b011001;
   localparam logic [5:0] OP_ALU_SUB  = 6'b011011;
   localparam logic [5:0] OP_ALU_AND  = 6'b011101;
   localparam logic [5:0] OP_ALU_OR   = 6'b011111;
   localparam logic [5:0] OP_ALU_XOR  = 6'b100001;
   localparam logic [5:0] OP_ALU_SLT  = 6'b100011;
   localparam logic [5:0] OP_ALU_SLTU = 6'b100101;
   localparam logic [5:0] OP_ALU_SLL  = 6'b100111;
   localparam logic [5:0] OP_ALU_SRL  = 6'b101001;
   localparam logic [5:0] OP_ALU_SRA  = 6'b101011;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rd;
      logic       illegal;
   } d_ctl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP/OP-IMM decoder: ALU op code, legality, immediate select and value.
// Zero latency; no state, no flow control.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output logic [5:0]  op,
   output logic        illegal,
   output logic        use_imm,
   output logic [31:0] imm
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       is_op;
   logic       is_imm;
   logic       is_shift;
   logic       legal;
   logic       unused_fields;

   assign opc      = instr[6:0];
   assign f3       = instr[14:12];
   assign f7       = instr[31:25];
   assign is_op    = (opc == OPC_OP);
   assign is_imm   = (opc == OPC_OP_IMM);
   assign is_shift = (f3 == F3_SLL) || (f3 == F3_SR);

   // Register indices are not needed to pick the ALU operation.
   assign unused_fields = &{1'b0, instr[19:15], instr[11:7]};

   always_comb begin
      legal = 1'b0;
      if (is_op) begin
         legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      end else if (is_imm) begin
         if (f3 == F3_SLL)
            legal = (f7 == F7_BASE);
         else if (f3 == F3_SR)
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
         else
            legal = 1'b1;
      end
   end

   always_comb begin
      op = OP_ALU_NOP;
      if (legal) begin
         case (f3)
            F3_ADD:  op = (is_op && (f7 == F7_ALT)) ? OP_ALU_SUB : OP_ALU_ADD;
            F3_SLL:  op = OP_ALU_SLL;
            F3_SLT:  op = OP_ALU_SLT;
            F3_SLTU: op = OP_ALU_SLTU;
            F3_XOR:  op = OP_ALU_XOR;
            F3_SR:   op = (f7 == F7_ALT) ? OP_ALU_SRA : OP_ALU_SRL;
            F3_OR:   op = OP_ALU_OR;
            default: op = OP_ALU_AND;
         endcase
      end
   end

   assign illegal = !legal;
   assign use_imm = is_imm;
   // Shift immediates carry only the 5-bit shamt; bit 30 selects SRAI and must not leak into B.
   assign imm     = (is_imm && is_shift) ? {27'b0, instr[24:20]}
                                         : {{20{instr[31]}}, instr[31:20]};

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for the RV32 ALU: decode into D, drive the ALU from D, capture the result into W.
// Accept at edge N, ALU operands after N, writeback after N+1; D/W stall on !i_wb_ready, o_ready drops when both full.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [31:0]           i_instr,
   input  logic [DATA_WIDTH-1:0] i_rs1_val,
   input  logic [DATA_WIDTH-1:0] i_rs2_val,
   output logic [5:0]            o_alu_op,
   output logic [DATA_WIDTH-1:0] o_alu_a,
   output logic [DATA_WIDTH-1:0] o_alu_b,
   input  logic [DATA_WIDTH-1:0] i_alu_c,
   output logic                  o_wb_valid,
   input  logic                  i_wb_ready,
   output logic [4:0]            o_wb_rd,
   output logic                  o_wb_we,
   output logic [DATA_WIDTH-1:0] o_wb_data,
   output logic                  o_wb_illegal
);

   logic                  d_valid;
   d_ctl_t                d_ctl;
   logic [DATA_WIDTH-1:0] d_a;
   logic [DATA_WIDTH-1:0] d_b;

   logic        w_free;
   logic        d_adv;
   logic        accept;

   logic [5:0]  dec_op;
   logic        dec_illegal;
   logic        dec_use_imm;
   logic [31:0] dec_imm;

   alu_op_decode u_decode (
      .instr   (i_instr),
      .op      (dec_op),
      .illegal (dec_illegal),
      .use_imm (dec_use_imm),
      .imm     (dec_imm)
   );

   assign w_free  = !o_wb_valid || i_wb_ready;
   assign d_adv   = d_valid && w_free;
   assign o_ready = !i_rst && (!d_valid || d_adv);
   assign accept  = i_valid && o_ready;

   // A bubble in D must present NOP so the ALU sees no stale operation.
   assign o_alu_op = d_valid ? d_ctl.op : OP_ALU_NOP;
   assign o_alu_a  = d_a;
   assign o_alu_b  = d_b;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         d_valid <= 1'b0;
         d_ctl   <= '0;
         d_a     <= '0;
         d_b     <= '0;
      end else if (accept) begin
         d_valid <= 1'b1;
         d_ctl   <= '{op: dec_op, rd: i_instr[11:7], illegal: dec_illegal};
         d_a     <= i_rs1_val;
         d_b     <= dec_use_imm ? dec_imm : i_rs2_val;
      end else if (d_adv) begin
         d_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wb_valid   <= 1'b0;
         o_wb_rd      <= '0;
         o_wb_we      <= 1'b0;
         o_wb_data    <= '0;
         o_wb_illegal <= 1'b0;
      end else if (d_adv) begin
         o_wb_valid   <= 1'b1;
         o_wb_rd      <= d_ctl.rd;
         o_wb_we      <= !d_ctl.illegal && (d_ctl.rd != 5'd0);
         o_wb_data    <= d_ctl.illegal ? '0 : i_alu_c;
         o_wb_illegal <= d_ctl.illegal;
      end else if (i_wb_ready) begin
         o_wb_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps plus random traffic against an instruction-level model.
module tb_alu_issue_stage;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_wb_ready = 1'b0;
   logic [31:0] i_instr = '0;
   logic [31:0] i_rs1_val = '0;
   logic [31:0] i_rs2_val = '0;
   logic [31:0] i_alu_c;
   logic        o_ready;
   logic [5:0]  o_alu_op;
   logic [31:0] o_alu_a;
   logic [31:0] o_alu_b;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd;
   logic        o_wb_we;
   logic [31:0] o_wb_data;
   logic        o_wb_illegal;

   always #5 i_clk = ~i_clk;

   alu_issue_stage #(.DATA_WIDTH(32)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_instr      (i_instr),
      .i_rs1_val    (i_rs1_val),
      .i_rs2_val    (i_rs2_val),
      .o_alu_op     (o_alu_op),
      .o_alu_a      (o_alu_a),
      .o_alu_b      (o_alu_b),
      .i_alu_c      (i_alu_c),
      .o_wb_valid   (o_wb_valid),
      .i_wb_ready   (i_wb_ready),
      .o_wb_rd      (o_wb_rd),
      .o_wb_we      (o_wb_we),
      .o_wb_data    (o_wb_data),
      .o_wb_illegal (o_wb_illegal)
   );

   // External combinational ALU; NOP returns a marker so forced-zero data on illegal words is visible.
   always_comb begin
      case (o_alu_op)
         6'b011001: i_alu_c = o_alu_a + o_alu_b;
         6'b011011: i_alu_c = o_alu_a - o_alu_b;
         6'b011101: i_alu_c = o_alu_a & o_alu_b;
         6'b011111: i_alu_c = o_alu_a | o_alu_b;
         6'b100001: i_alu_c = o_alu_a ^ o_alu_b;
         6'b100011: i_alu_c = {31'b0, $signed(o_alu_a) < $signed(o_alu_b)};
         6'b100101: i_alu_c = {31'b0, o_alu_a < o_alu_b};
         6'b100111: i_alu_c = o_alu_a << o_alu_b[4:0];
         6'b101001: i_alu_c = o_alu_a >> o_alu_b[4:0];
         6'b101011: i_alu_c = $signed(o_alu_a) >>> o_alu_b[4:0];
         default:   i_alu_c = 32'hDEADBEEF;
      endcase
   end

   typedef struct packed {
      logic [4:0]  rd;
      logic        we;
      logic        ill;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_deliv = 0;
   bit   hold_prev = 1'b0;
   bit   rst_prev = 1'b1;
   exp_t hold_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Instruction semantics: alt selects SUB/SRA.
   function automatic logic [31:0] sem(input logic [2:0] f3, input bit alt,
                                       input logic [31:0] x, input logic [31:0] y);
      case (f3)
         3'd0:    return alt ? x - y : x + y;
         3'd1:    return x << y[4:0];
         3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         3'd3:    return (x < y) ? 32'd1 : 32'd0;
         3'd4:    return x ^ y;
         3'd5:    return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
         3'd6:    return x | y;
         default: return x & y;
      endcase
   endfunction

   function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      bit          legal;
      bit          alt;
      logic [31:0] r;
      logic [2:0]  f3;
      logic [6:0]  f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      alt = (f7 == 7'h20);
      legal = 1'b0;
      r = '0;
      if (ins[6:0] == 7'h33) begin
         legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
         r = sem(f3, alt, x, y);
      end else if (ins[6:0] == 7'h13) begin
         if (f3 == 3'd1)      legal = (f7 == 7'h00);
         else if (f3 == 3'd5) legal = (f7 == 7'h00) || alt;
         else                 legal = 1'b1;
         r = sem(f3, (f3 == 3'd5) && alt, x, {{20{ins[31]}}, ins[31:20]});
      end
      e.rd   = ins[11:7];
      e.ill  = !legal;
      e.we   = legal && (ins[11:7] != 5'd0);
      e.data = legal ? r : 32'd0;
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      int          k;
      int          f;
      w = $urandom;
      k = $urandom_range(0, 7);
      f = $urandom_range(0, 3);
      if (k < 4)      w[6:0] = 7'h33;
      else if (k < 7) w[6:0] = 7'h13;
      if (k < 7) begin
         if (f < 2)       w[31:25] = 7'h00;
         else if (f == 2) w[31:25] = 7'h20;
      end
      return w;
   endfunction

   // One cycle: called at a falling edge with inputs already driven.
   task automatic tick(output bit acc);
      bit   wx;
      exp_t e;
      #1;
      if (hold_prev && !rst_prev) begin
         chk("wb_hold_valid", {31'b0, o_wb_valid}, 32'd1);
         chk("wb_hold_ctl", {25'b0, o_wb_rd, o_wb_we, o_wb_illegal}, {25'b0, hold_q.rd, hold_q.we, hold_q.ill});
         chk("wb_hold_data", o_wb_data, hold_q.data);
      end
      acc = i_valid && o_ready;
      wx  = o_wb_valid && i_wb_ready;
      if (wx) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected", {31'b0, o_wb_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("wb_rd", {27'b0, o_wb_rd}, {27'b0, e.rd});
            chk("wb_we", {31'b0, o_wb_we}, {31'b0, e.we});
            chk("wb_illegal", {31'b0, o_wb_illegal}, {31'b0, e.ill});
            chk("wb_data", o_wb_data, e.data);
            n_deliv++;
         end
      end
      if (acc) sb.push_back(ref_exec(i_instr, i_rs1_val, i_rs2_val));
      hold_prev = o_wb_valid && !i_wb_ready;
      rst_prev  = i_rst;
      hold_q    = '{rd: o_wb_rd, we: o_wb_we, ill: o_wb_illegal, data: o_wb_data};
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic drain();
      bit a;
      i_valid = 1'b0;
      i_wb_ready = 1'b1;
      for (int k = 0; k < 20 && sb.size() != 0; k++) tick(a);
      chk("drain_empty", sb.size(), 32'd0);
   endtask

   initial begin
      bit          a;
      int          idx;
      int          n0;
      logic [31:0] stream [8];
      logic [5:0]  s_op;
      logic [31:0] s_a;
      logic [31:0] s_b;

      // Reset held with a request pending
      @(negedge i_clk);
      i_valid = 1'b1;
      i_instr = 32'h002081B3;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rst_ready", {31'b0, o_ready}, 32'd0);
         chk("rst_wb_valid", {31'b0, o_wb_valid}, 32'd0);
         chk("rst_alu_op", {26'b0, o_alu_op}, 32'd0);
         tick(a);
      end
      i_rst = 1'b0;
      i_valid = 1'b0;
      i_wb_ready = 1'b1;
      #1;
      chk("post_rst_ready", {31'b0, o_ready}, 32'd1);
      chk("post_rst_wbv", {31'b0, o_wb_valid}, 32'd0);
      tick(a);

      // ADD x3,x1,x2
      i_instr = 32'h002081B3; i_rs1_val = 32'd5; i_rs2_val = 32'd7; i_valid = 1'b1;
      tick(a);
      i_valid = 1'b0;
      chk("add_op", {26'b0, o_alu_op}, {26'b0, 6'b011001});
      chk("add_a", o_alu_a, 32'd5);
      chk("add_b", o_alu_b, 32'd7);
      chk("add_wbv_early", {31'b0, o_wb_valid}, 32'd0);
      tick(a);
      chk("add_wbv", {31'b0, o_wb_valid}, 32'd1);
      chk("add_rd", {27'b0, o_wb_rd}, 32'd3);
      chk("add_we", {31'b0, o_wb_we}, 32'd1);
      chk("add_data", o_wb_data, 32'd12);
      drain();

      // ADDI x1,x0,-1 then SRAI x5,x5,4
      i_instr = 32'hFFF00093; i_rs1_val = 32'h1234_5678; i_valid = 1'b1;
      tick(a);
      chk("addi_op", {26'b0, o_alu_op}, {26'b0, 6'b011001});
      chk("addi_b", o_alu_b, 32'hFFFF_FFFF);
      i_instr = 32'h4042D293; i_rs1_val = 32'h8000_0F00;
      tick(a);
      i_valid = 1'b0;
      chk("srai_op", {26'b0, o_alu_op}, {26'b0, 6'b101011});
      chk("srai_b", o_alu_b, 32'd4);
      drain();

      // Illegal words and a write to x0
      i_valid = 1'b1; i_rs1_val = $urandom; i_rs2_val = $urandom;
      i_instr = 32'h0000006F;
      tick(a);
      chk("jal_alu_op", {26'b0, o_alu_op}, 32'd0);
      i_instr = 32'h022081B3;
      tick(a);
      i_instr = 32'h00208033;
      tick(a);
      drain();

      // Back-to-back stream of 8 with a 3-cycle writeback stall
      for (int k = 0; k < 8; k++) stream[k] = gen_instr();
      idx = 0;
      n0 = n_deliv;
      s_op = '0; s_a = '0; s_b = '0;
      for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
         i_instr = stream[idx];
         i_rs1_val = $urandom;
         i_rs2_val = $urandom;
         i_valid = 1'b1;
         i_wb_ready = !(cyc >= 3 && cyc <= 5);
         #1;
         if (cyc >= 3 && cyc <= 5) chk("stall_ready", {31'b0, o_ready}, 32'd0);
         if (cyc == 3) begin
            s_op = o_alu_op; s_a = o_alu_a; s_b = o_alu_b;
         end
         if (cyc == 4 || cyc == 5) begin
            chk("stall_alu_op", {26'b0, o_alu_op}, {26'b0, s_op});
            chk("stall_alu_a", o_alu_a, s_a);
            chk("stall_alu_b", o_alu_b, s_b);
         end
         tick(a);
         if (a) idx++;
      end
      drain();
      chk("stream_count", n_deliv - n0, 32'd8);

      // Random traffic with random backpressure
      for (int cyc = 0; cyc < 400; cyc++) begin
         i_instr = gen_instr();
         i_rs1_val = $urandom;
         i_rs2_val = $urandom;
         i_valid = ($urandom_range(0, 3) != 0);
         i_wb_ready = ($urandom_range(0, 3) != 0);
         tick(a);
      end
      drain();

      // Reset with both stages full
      i_wb_ready = 1'b0;
      i_valid = 1'b1;
      i_instr = 32'h002081B3; i_rs1_val = 32'd1; i_rs2_val = 32'd2;
      tick(a);
      i_instr = 32'h00310233;
      tick(a);
      #1;
      chk("full_ready", {31'b0, o_ready}, 32'd0);
      chk("full_wbv", {31'b0, o_wb_valid}, 32'd1);
      i_rst = 1'b1;
      tick(a);
      sb.delete();
      chk("mid_rst_wbv", {31'b0, o_wb_valid}, 32'd0);
      chk("mid_rst_alu_op", {26'b0, o_alu_op}, 32'd0);
      i_rst = 1'b0;
      i_valid = 1'b0;
      i_wb_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(a);
         chk("no_stale_wbv", {31'b0, o_wb_valid}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Upstream driver and result consumer for the RV32 combinational ALU. Accepts RV32I OP and OP-IMM instruction words with register operands over a valid/ready handshake. Decodes each word into the 6-bit ALU operation code and drives the ALU operand ports. Captures the ALU result into a registered writeback output. Sits between the register-file read stage and writeback.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported.

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  issue request valid
o_ready  output  1  stage can accept the request this cycle
i_instr  input  32  RV32I instruction word
i_rs1_val  input  DATA_WIDTH  rs1 register value
i_rs2_val  input  DATA_WIDTH  rs2 register value
o_alu_op  output  6  ALU operation code to the ALU
o_alu_a  output  DATA_WIDTH  ALU operand A
o_alu_b  output  DATA_WIDTH  ALU operand B
i_alu_c  input  DATA_WIDTH  ALU result (combinational from o_alu_*)
o_wb_valid  output  1  writeback entry valid
i_wb_ready  input  1  writeback consumer accepts
o_wb_rd  output  5  destination register
o_wb_we  output  1  register write enable
o_wb_data  output  DATA_WIDTH  result
o_wb_illegal  output  1  instruction not a legal OP/OP-IMM encoding

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Pipeline registers:
  - D stage holds d_valid, decoded op, A, B, rd, illegal.
  - W stage holds the writeback fields.
- Reset values: d_valid=0, o_wb_valid=0, o_wb_rd=0, o_wb_we=0, o_wb_data=0, o_wb_illegal=0, o_alu_op=6'b000000 (NOP), o_alu_a=0, o_alu_b=0.
- While i_rst is high, o_ready=0. Reset mid-operation discards both stages with no writeback emitted.
- Handshake:
  - Input transfer when i_valid && o_ready.
  - Output transfer when o_wb_valid && i_wb_ready.
  - o_wb_* stays stable while o_wb_valid && !i_wb_ready.
- Flow control:
  - w_free = !o_wb_valid || i_wb_ready.
  - d_adv = d_valid && w_free.
  - o_ready = !d_valid || d_adv (combinational, no dependency on i_valid).
- Latency: accept at edge N, o_alu_* valid after N, o_wb_valid after edge N+1. Throughput is 1 per cycle with i_wb_ready held high.
- Simultaneous accept and advance: D reloads with the new instruction on the same edge W captures i_alu_c.
- Stall: with W full and !i_wb_ready, D holds and o_alu_* stay constant.
- o_alu_* are driven from D registers only. A bubble (d_valid=0) drives NOP.
- Decode, opcode i_instr[6:0]:
  - 0110011 (OP): B=rs2.
  - 0010011 (OP-IMM): B=sign-extended imm[31:20].
  - A=rs1 in both cases.
- funct3 mapping:
  - 000: ADD; SUB only for OP with funct7=0100000.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL (funct7=0000000) or SRA (funct7=0100000).
  - 110: OR.
  - 111: AND.
- Legality:
  - OP requires funct7 of 0000000, or 0100000 only with funct3 000/101.
  - OP-IMM SLLI requires funct7=0000000; SRLI/SRAI as for OP; other OP-IMM funct3 ignore bits 31:25.
  - OP-IMM shifts take B = {27'b0, instr[24:20]}.
  - Any other opcode or funct7 is illegal.
- Illegal instruction: op=NOP, o_wb_illegal=1, o_wb_we=0, o_wb_data=0. It still occupies one slot and is delivered in order.
- o_wb_rd=instr[11:7]. o_wb_we=legal && rd!=0.

Decomposition:
- Shared package alu_pkg holds:
  - OP_ALU_* codes: NOP 000000, ADD 011001, SUB 011011, AND 011101, OR 011111, XOR 100001, SLT 100011, SLTU 100101, SLL 100111, SRL 101001, SRA 101011.
  - OPC_OP=0110011, OPC_OP_IMM=0010011.
  - funct3/funct7 constants.
  - DATA_WIDTH=32.
- One combinational sub-module, alu_op_decode: instr in, op/illegal/use_imm/imm out.

Test Plan:
- Reset with i_valid=1: o_ready=0, o_wb_valid=0, o_alu_op=000000 throughout. After release, o_ready=1 with W empty.
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> o_alu_op=011001, A=5, B=7. Two edges later o_wb_valid=1, rd=3, we=1, data=12 from the ALU.
- ADDI x1,x0,-1 (0xFFF00093) -> B=0xFFFFFFFF. SRAI x5,x5,4 (0x4042D293) -> op=101011, B=4.
- Back-to-back stream of 8 instructions with i_wb_ready held low for 3 cycles mid-stream:
  - o_ready drops after D and W fill.
  - o_wb_* hold stable during the stall.
  - All 8 results delivered in order, none lost or duplicated.
- Illegal words (0x0000006F JAL; OP with funct7=0000001) -> o_wb_illegal=1, we=0, data=0, delivered in order. A write to rd=0 (ADD x0,x1,x2) -> we=0, illegal=0.
- Assert i_rst with both stages full -> next cycle o_wb_valid=0, d_valid=0, and no stale result appears after reset release.
